alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequencer and arbiter that shares one combinational `alu` instance between two requesters, such as a CPU datapath port and a board or debug port. It uses valid/ready handshakes. The block accepts one operation at a time, registers the operands and opcode, drives the ALU through `alu_if`, captures result and flags one cycle later, and holds the response until it is consumed. It sits between the requesters and the `alu` instance, so the ALU never sees operand changes mid-operation.

## Interface
- `DATA_W`, default 32: operand and result width.
- `OP_W`, default 4: opcode width; matches `aluop_t`.
- `CNT_W`, default 16: width of the completed-operation counter.

- `CLK`  in  1  system clock; all state changes on the rising edge.
- `nRST`  in  1  asynchronous reset, active low.
- `req_valid`  in  2  bit i: requester i presents an operation.
- `req_ready`  out  2  bit i: operation from requester i is accepted this cycle (one-hot or zero).
- `req_op0`, `req_op1`  in  OP_W  opcode per requester.
- `req_a0`, `req_a1`, `req_b0`, `req_b1`  in  DATA_W  operands per requester.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_id`  out  1  requester the response belongs to.
- `rsp_result`  out  DATA_W  captured `port_o`.
- `rsp_zero`, `rsp_neg`, `rsp_ov`  out  1  captured flags.
- `aluif`  modport to `alu_if`: drives `port_a`, `port_b`, `aluop`; samples `port_o`, `zero`, `neg`, `ov`.
- `busy`  out  1  high in EXEC or RESP.
- `op_count`  out  CNT_W  completed response handshakes.

## Operation
- There are three states: IDLE, EXEC and RESP.
- **IDLE**
  - If any `req_valid` bit is set, select a winner and pulse its `req_ready` bit for one cycle.
  - Latch the winner's opcode and operands into the operand registers, and its index into `rsp_id`.
  - Go to EXEC.
  - `req_ready` is 0 in every other state.
- **EXEC**
  - The ALU inputs are driven only from the operand registers, never directly from the requester ports.
  - Capture `port_o`, `zero`, `neg` and `ov` into the `rsp_*` registers, and go to RESP.
- **RESP**
  - `rsp_valid` is 1, and all `rsp_*` outputs are held stable.
  - On `rsp_valid && rsp_ready`, increment `op_count` (wrapping modulo 2^CNT_W) and go to IDLE.
  - A new request can be granted no earlier than the following cycle.
- **Requester rules**
  - A requester holds valid, opcode and operands stable until its ready bit is seen.
  - Deasserting valid before ready is legal; that request is simply not taken.
- **Idle ALU inputs:** in IDLE the ALU inputs keep the last registered values. The ALU output is ignored.
- **Arbitration:** selection follows the rule in Configuration. The `last_grant` register updates on every grant.
- **Width rules:** result and flags pass through the ALU unmodified, with no sign extension or truncation in this block.

## Timing
- **Reset values:**
  - State IDLE.
  - `req_ready`, `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_zero`, `rsp_neg`, `rsp_ov`, `busy`, `op_count` all 0.
  - Operand and opcode registers 0.
  - `last_grant` = 1, so requester 0 wins the first conflict.
- **Latency:** grant in cycle N, capture at the end of N+1, `rsp_valid` is 1 from cycle N+2.
- **Throughput:** at best one operation per 3 cycles, with `rsp_ready` held high.
- **Back-pressure:** while `rsp_ready` = 0, RESP is held indefinitely with all outputs stable. No request is granted during this time.
- **Simultaneous requests:** both `req_valid` bits set in IDLE produces exactly one grant; the other requester stays pending.
- **Reset mid-operation:** asserting `nRST` in EXEC or RESP discards the operation. No response is issued and `op_count` returns to 0.

## Configuration
- Macro: `ALU_ARB_ROUND_ROBIN_EN`.
- **Defined:** round-robin arbitration. On conflict, the requester other than `last_grant` wins, so grants alternate under continuous contention.
- **Undefined:** fixed priority; requester 0 always wins a conflict. `last_grant` is still maintained but does not affect selection.

## Test plan
- **Single ADD:** `req_valid`=01, op=ALU_ADD (4'b0010), a=5, b=7.
  - Required: `req_ready`=01 in cycle N.
  - Required: `rsp_valid` in cycle N+2 with `rsp_result`=12, `rsp_id`=0, zero=neg=ov=0.
  - Required: `op_count`=1 after handshake.
- **Overflow and negative:** requester 1, ALU_ADD, a=32'h7FFFFFFF, b=1.
  - Required: `rsp_result`=32'h80000000, ov=1, neg=1, `rsp_id`=1.
- **Contention:** both valid continuously, `rsp_ready`=1.
  - With the macro defined: grants go 0,1,0,1.
  - Without the macro: grants go 0,0,0.
- **Back-pressure:** ALU_SUB, a=3, b=3, `rsp_ready`=0 for 10 cycles.
  - Required during the stall: `rsp_result`=0 with zero=1 held stable, `req_ready`=00 despite a pending request.
  - Required on release: the response is consumed and the pending request is granted the following cycle.
- **Stable operands:** change `req_a0` to 32'hFFFF after the grant.
  - Required: the result reflects the originally latched operand.
- **Reset in EXEC:** assert `nRST` low during EXEC.
  - Required: all outputs go to 0 immediately and `rsp_valid` never asserts for that operation.
  - Required: after release, requester 0 wins a conflict.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Connection bundle between the ALU sequencer and the shared combinational ALU.
// The arbiter side drives operands/opcode and samples result and flags.
interface alu_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4
);
    logic [DATA_W-1:0] port_a;
    logic [DATA_W-1:0] port_b;
    logic [OP_W-1:0]   aluop;
    logic [DATA_W-1:0] port_o;
    logic              zero;
    logic              neg;
    logic              ov;

    modport arb (
        output port_a,
        output port_b,
        output aluop,
        input  port_o,
        input  zero,
        input  neg,
        input  ov
    );

    modport alu (
        input  port_a,
        input  port_b,
        input  aluop,
        output port_o,
        output zero,
        output neg,
        output ov
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester valid/ready sequencer in front of one shared combinational ALU.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module alu_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [OP_W-1:0]   req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_b1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_neg,
    output logic              rsp_ov,
    alu_if.arb                aluif,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e            state_q;
    logic              last_grant_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [1:0]        grant;
    logic              sel;

    // Grant is decided combinationally so the handshake refers to the current valid.
    always_comb begin
        grant = 2'b00;
        if (state_q == StIdle) begin
            unique case (req_valid)
                2'b01: grant = 2'b01;
                2'b10: grant = 2'b10;
                2'b11: begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
                    grant = last_grant_q ? 2'b01 : 2'b10;
`else
                    grant = 2'b01;
`endif
                end
                default: grant = 2'b00;
            endcase
        end
    end

    assign sel       = grant[1];
    assign req_ready = nRST ? grant : 2'b00;

    // The ALU only ever sees registered operands.
    assign aluif.port_a = a_q;
    assign aluif.port_b = b_q;
    assign aluif.aluop  = op_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_neg      <= 1'b0;
            rsp_ov       <= 1'b0;
            busy         <= 1'b0;
            op_count     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|grant) begin
                        op_q         <= sel ? req_op1 : req_op0;
                        a_q          <= sel ? req_a1 : req_a0;
                        b_q          <= sel ? req_b1 : req_b0;
                        rsp_id       <= sel;
                        last_grant_q <= sel;
                        busy         <= 1'b1;
                        state_q      <= StExec;
                    end
                end
                StExec: begin
                    rsp_result <= aluif.port_o;
                    rsp_zero   <= aluif.zero;
                    rsp_neg    <= aluif.neg;
                    rsp_ov     <= aluif.ov;
                    rsp_valid  <= 1'b1;
                    state_q    <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The operation in flight always belongs to the most recent grant.
    a_grant_matches_id: assert property (@(posedge CLK) disable iff (!nRST)
        (state_q != StIdle) |-> (last_grant_q == rsp_id));

    a_ready_onehot: assert property (@(posedge CLK) disable iff (!nRST)
        $onehot0(req_ready));

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a latency/arbitration reference model.
module tb_alu_arbiter;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_neg, rsp_ov;
    logic        busy;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one operation in flight, response two cycles after grant.
    bit          m_inflight;
    int          m_age;
    bit          m_last;
    int unsigned m_cnt;
    logic        exp_id;
    logic [31:0] exp_res;
    logic        exp_z, exp_n, exp_v;
    logic [1:0]  last_grant_exp;
    bit          glog[$];
    bit          pend[2];

    alu_if #(.DATA_W(32), .OP_W(4)) aluif ();

    alu_arbiter #(.DATA_W(32), .OP_W(4), .CNT_W(16)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .req_a0    (req_a0),
        .req_a1    (req_a1),
        .req_b0    (req_b0),
        .req_b1    (req_b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_result(rsp_result),
        .rsp_zero  (rsp_zero),
        .rsp_neg   (rsp_neg),
        .rsp_ov    (rsp_ov),
        .aluif     (aluif),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [34:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint s;
        logic [31:0] r;
        logic v;
        s = 0;
        v = 1'b0;
        case (op)
            ALU_ADD: s = longint'($signed(a)) + longint'($signed(b));
            ALU_SUB: s = longint'($signed(a)) - longint'($signed(b));
            ALU_AND: s = longint'(a & b);
            ALU_OR:  s = longint'(a | b);
            ALU_XOR: s = longint'(a ^ b);
            default: s = 0;
        endcase
        r = s[31:0];
        if (op == ALU_ADD || op == ALU_SUB)
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {r, (r == 32'd0), r[31], v};
    endfunction

    // Stand-in for the shared combinational ALU.
    assign {aluif.port_o, aluif.zero, aluif.neg, aluif.ov} =
        alu_ref(aluif.aluop, aluif.port_a, aluif.port_b);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] pick(input logic [1:0] v);
        case (v)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            2'b11:   return m_last ? 2'b01 : 2'b10;
`else
            2'b11:   return 2'b01;
`endif
            default: return 2'b00;
        endcase
    endfunction

    // One clock cycle: sample at the falling edge, advance the model, return at posedge+1.
    task automatic tick();
        logic [1:0] e_ready;
        logic       e_rv;
        logic       w;
        @(negedge CLK);
        e_ready = m_inflight ? 2'b00 : pick(req_valid);
        e_rv    = m_inflight && (m_age >= 2);
        check("req_ready", req_ready, e_ready);
        check("rsp_valid", rsp_valid, e_rv);
        check("busy", busy, m_inflight);
        check("op_count", op_count, m_cnt);
        if (e_rv) begin
            check("rsp_id", rsp_id, exp_id);
            check("rsp_result", rsp_result, exp_res);
            check("rsp_flags", {rsp_zero, rsp_neg, rsp_ov}, {exp_z, exp_n, exp_v});
        end
        if (req_ready != 2'b00) glog.push_back(req_ready[1]);
        if (e_rv && rsp_ready) begin
            m_inflight = 1'b0;
            m_cnt      = (m_cnt + 1) % 65536;
        end else if (m_inflight && m_age < 2) begin
            m_age++;
        end
        if (e_ready != 2'b00) begin
            w      = e_ready[1];
            m_last = w;
            exp_id = w;
            {exp_res, exp_z, exp_n, exp_v} = w ? alu_ref(req_op1, req_a1, req_b1)
                                               : alu_ref(req_op0, req_a0, req_b0);
            m_inflight = 1'b1;
            m_age      = 1;
        end
        last_grant_exp = e_ready;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        if (i == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rand_op();
        logic [3:0] ops [5];
        ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR};
        return ops[$urandom_range(4)];
    endfunction

    task automatic model_reset();
        m_inflight = 1'b0;
        m_age      = 0;
        m_last     = 1'b1;
        m_cnt      = 0;
    endtask

    initial begin
        nRST      = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        set_req(0, 4'd0, 32'd0, 32'd0);
        set_req(1, 4'd0, 32'd0, 32'd0);
        model_reset();
        last_grant_exp = 2'b00;

        // Reset values
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", req_ready, 2'b00);
        check("rst_rsp", {rsp_valid, rsp_id, rsp_zero, rsp_neg, rsp_ov, busy}, 6'b0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_count", op_count, 16'd0);
        check("rst_operands", {aluif.port_a, aluif.port_b, aluif.aluop}, 68'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Single ADD from requester 0
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        tick();
        req_valid = 2'b00;
        tick();
        check("add_result", rsp_result, 32'd12);
        check("add_id_flags", {rsp_valid, rsp_id, rsp_zero, rsp_neg, rsp_ov}, 5'b10000);
        tick();
        check("add_count", op_count, 16'd1);

        // Overflow and negative from requester 1
        req_valid = 2'b10;
        set_req(1, ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        tick();
        req_valid = 2'b00;
        tick();
        check("ov_result", rsp_result, 32'h8000_0000);
        check("ov_id_flags", {rsp_id, rsp_neg, rsp_ov}, 3'b111);
        tick();

        // Continuous contention
        glog.delete();
        req_valid = 2'b11;
        for (int c = 0; c < 12; c++) begin
            set_req(0, rand_op(), rand_operand(), rand_operand());
            set_req(1, rand_op(), rand_operand(), rand_operand());
            tick();
        end
        req_valid = 2'b00;
        check("cont_grants", glog.size(), 4);
        for (int k = 0; k < 4; k++) begin
            logic exp_w;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            exp_w = k[0];
`else
            exp_w = 1'b0;
`endif
            check($sformatf("cont_grant%0d", k), (k < glog.size()) ? glog[k] : 1'bx, exp_w);
        end

        // Back-pressure with a pending request from requester 1
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        set_req(0, ALU_SUB, 32'd3, 32'd3);
        tick();
        req_valid = 2'b10;
        set_req(1, ALU_ADD, 32'd1, 32'd1);
        tick();
        for (int c = 0; c < 10; c++) begin
            check("bp_result", rsp_result, 32'd0);
            check("bp_zero", rsp_zero, 1'b1);
            check("bp_ready", req_ready, 2'b00);
            tick();
        end
        rsp_ready = 1'b1;
        glog.delete();
        tick();
        check("bp_no_same_cycle_grant", glog.size(), 0);
        tick();
        check("bp_next_grant", (glog.size() == 1) ? glog[0] : 1'bx, 1'b1);
        req_valid = 2'b00;
        repeat (3) tick();

        // Operands changed after the grant must not affect the result
        req_valid = 2'b01;
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        tick();
        req_valid = 2'b00;
        req_a0    = 32'h0000_FFFF;
        tick();
        check("stable_result", rsp_result, 32'd3);
        tick();

        // Reset while in EXEC
        req_valid = 2'b01;
        set_req(0, ALU_ADD, 32'd4, 32'd4);
        tick();
        req_valid = 2'b11;
        #1 nRST = 1'b0;
        #1;
        check("rst_exec_ready", req_ready, 2'b00);
        check("rst_exec_rsp", {rsp_valid, rsp_id, rsp_zero, rsp_neg, rsp_ov, busy}, 6'b0);
        check("rst_exec_result", rsp_result, 32'd0);
        check("rst_exec_count", op_count, 16'd0);
        model_reset();
        req_valid = 2'b00;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        glog.delete();
        req_valid = 2'b11;
        tick();
        check("rst_exec_first_win", (glog.size() == 1) ? glog[0] : 1'bx, 1'b0);

        // Randomized traffic
        pend[0] = 1'b0;
        pend[1] = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1'b1;
                    set_req(i, rand_op(), rand_operand(), rand_operand());
                end else if (pend[i] && $urandom_range(15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            req_valid = {pend[1], pend[0]};
            rsp_ready = ($urandom_range(3) != 0);
            tick();
            for (int i = 0; i < 2; i++) begin
                if (last_grant_exp[i]) begin
                    pend[i] = 1'b0;
                    if ($urandom_range(1) == 1)
                        set_req(i, rand_op(), rand_operand(), rand_operand());
                end
            end
        end

        // Drain
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (4) tick();
        check("drain_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
